// File: rtl/soc_bus_pkg.sv
// Shared bus-bridge definitions: bridge FSM states, APB strobe width, default timeout.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  localparam int APB_STRB_W          = 4;
  localparam int DEFAULT_APB_TIMEOUT = 255;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS-phase cycle counter; expired holds once TIMEOUT cycles have elapsed.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && (cnt_q != LIMIT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_to_apb_bridge.sv
// Wishbone classic slave to APB4 master, one transfer in flight, with ACCESS timeout.
module wb_to_apb_bridge
  import soc_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_APB_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_adr,
  input  logic [DW-1:0]   wb_wdata,
  input  logic [DW/8-1:0] wb_sel,
  output logic [DW-1:0]   wb_rdata,
  output logic            wb_ack,
  output logic            wb_err,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [AW-1:0]   paddr,
  output logic [DW-1:0]   pwdata,
  output logic [DW/8-1:0] pstrb,
  input  logic [DW-1:0]   prdata,
  input  logic            pready,
  input  logic            pslverr
);

  bridge_state_e   state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            tmo_expired;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == ST_SETUP),
    .enable  ((state_q == ST_ACCESS) && !pready),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc && wb_stb) begin
          adr_d   = wb_adr;
          we_d    = wb_we;
          wdata_d = wb_wdata;
          sel_d   = wb_sel;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          err_d = pslverr;
          // an errored read leaves the previous read data in place
          if (!we_q && !pslverr) rdata_d = prdata;
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign psel     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable  = (state_q == ST_ACCESS);
  assign paddr    = adr_q;
  assign pwrite   = we_q;
  assign pwdata   = wdata_q;
  assign pstrb    = we_q ? sel_q : '0;
  assign wb_rdata = rdata_q;
  // an abandoned cycle (cyc low in RESP) gets no response pulse
  assign wb_ack   = (state_q == ST_RESP) && wb_cyc && !err_q;
  assign wb_err   = (state_q == ST_RESP) && wb_cyc && err_q;

endmodule

// File: tb/tb_wb_to_apb_bridge.sv
// Scoreboard bench for wb_to_apb_bridge with TIMEOUT=4 and a programmable APB slave.
module tb_wb_to_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel, pstrb;
  logic        wb_ack, wb_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  wb_to_apb_bridge #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_wdata(wb_wdata), .wb_sel(wb_sel), .wb_rdata(wb_rdata),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        is_err;
    logic        chk_rd;
    logic [31:0] rdata;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  // APB slave: pready after s_waits wait states in ACCESS
  int          s_waits = 0;
  logic        s_err = 1'b0;
  logic [31:0] s_rdata = '0;
  int          acc_n = 0;
  always @(negedge clk) begin
    if (psel && penable) begin
      pready  = (acc_n >= s_waits);
      pslverr = s_err && pready;
      prdata  = s_rdata;
      acc_n++;
    end else begin
      acc_n   = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
    end
  end

  // response monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (wb_ack || wb_err)) begin
      chk("ack_err_excl", {63'd0, wb_ack & wb_err}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("resp_is_err", {63'd0, wb_err}, {63'd0, e.is_err});
        chk("resp_cycle", 64'(cyc_n), 64'(e.at));
        if (e.chk_rd) chk("resp_rdata", {32'd0, wb_rdata}, {32'd0, e.rdata});
      end
    end
  end

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [3:0] sel, output int unsigned t0);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_wdata = wd; wb_sel = sel;
    t0 = cyc_n;
  endtask

  task automatic wait_resp(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = wb_ack | wb_err;
    end
    if (!seen) chk({tag, "_no_resp"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected done");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned t0;
    rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0;
    wb_adr = '0; wb_wdata = '0; wb_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel",  {63'd0, psel}, 64'd0);
    chk("rst_ack",   {62'd0, wb_ack, wb_err}, 64'd0);
    chk("rst_paddr", {32'd0, paddr}, 64'd0);
    chk("rst_rdata", {32'd0, wb_rdata}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait write
    s_waits = 0; s_err = 0;
    req(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, t0);
    sb.push_back('{1'b0, 1'b0, 32'd0, t0 + 3});
    @(negedge clk); chk("w_n_psel", {63'd0, psel}, 64'd0);
    @(negedge clk);
    chk("w_setup", {62'd0, psel, penable}, 64'd2);
    chk("w_paddr", {32'd0, paddr}, 64'h4000_0010);
    chk("w_pwdata", {32'd0, pwdata}, 64'hDEAD_BEEF);
    chk("w_pstrb", {59'd0, pwrite, pstrb}, 64'h1F);
    @(negedge clk); chk("w_access", {62'd0, psel, penable}, 64'd3);
    wait_resp("w"); end_req();

    // read with 3 wait states
    s_waits = 3; s_rdata = 32'h1234_5678;
    req(1'b0, 32'h4000_0020, 32'h0, 4'hF, t0);
    sb.push_back('{1'b0, 1'b1, 32'h1234_5678, t0 + 6});
    repeat (2) @(negedge clk);
    chk("r_pstrb", {59'd0, pwrite, pstrb}, 64'd0);
    wait_resp("r"); end_req();

    // read with pslverr: error pulse, read data held
    s_waits = 0; s_err = 1; s_rdata = 32'hAAAA_5555;
    req(1'b0, 32'h4000_0030, 32'h0, 4'h0, t0);
    sb.push_back('{1'b1, 1'b0, 32'd0, t0 + 3});
    wait_resp("slverr");
    chk("slverr_no_ack", {63'd0, wb_ack}, 64'd0);
    chk("slverr_rdata_held", {32'd0, wb_rdata}, 64'h1234_5678);
    end_req(); s_err = 0;

    // timeout with pready stuck low
    s_waits = 1000;
    req(1'b0, 32'h4000_0040, 32'h0, 4'h0, t0);
    sb.push_back('{1'b1, 1'b0, 32'd0, t0 + 7});
    repeat (7) @(negedge clk);
    chk("tmo_still_access", {62'd0, psel, penable}, 64'd3);
    wait_resp("tmo");
    chk("tmo_psel_drop", {63'd0, psel}, 64'd0);
    chk("tmo_rdata_zero", {32'd0, wb_rdata}, 64'd0);
    end_req();
    s_waits = 0;
    req(1'b1, 32'h4000_0044, 32'h0BAD_F00D, 4'h3, t0);
    sb.push_back('{1'b0, 1'b0, 32'd0, t0 + 3});
    wait_resp("after_tmo"); end_req();

    // abort: cyc dropped in ACCESS, APB still completes, no pulse
    s_waits = 2;
    req(1'b1, 32'h4000_0050, 32'h5555_AAAA, 4'hF, t0);
    repeat (2) @(posedge clk);
    #1 wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_apb_runs", {62'd0, psel, penable}, 64'd3);
    @(negedge clk);
    chk("abort_no_pulse", {61'd0, wb_ack, wb_err, psel}, 64'd0);
    repeat (2) @(negedge clk);

    // back-to-back with stb held high
    s_waits = 0; s_rdata = 32'hCAFE_F00D;
    req(1'b0, 32'h4000_0060, 32'h0, 4'hF, t0);
    sb.push_back('{1'b0, 1'b1, 32'hCAFE_F00D, t0 + 3});
    sb.push_back('{1'b0, 1'b1, 32'hCAFE_F00D, t0 + 7});
    wait_resp("b2b_1");
    @(negedge clk); chk("b2b_idle_gap", {63'd0, psel}, 64'd0);
    @(negedge clk); chk("b2b_setup2", {62'd0, psel, penable}, 64'd2);
    wait_resp("b2b_2"); end_req();

    // reset during ACCESS
    s_waits = 1000;
    req(1'b1, 32'h4000_0070, 32'hFFFF_FFFF, 4'hF, t0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_ctl", {60'd0, psel, penable, pwrite, wb_ack | wb_err}, 64'd0);
    chk("rstmid_paddr", {32'd0, paddr}, 64'd0);
    chk("rstmid_pwdata", {28'd0, pstrb, pwdata}, 64'd0);
    @(posedge clk); #1 rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    s_waits = 0; s_rdata = 32'h0F0F_1234;
    req(1'b0, 32'h4000_0080, 32'h0, 4'h0, t0);
    sb.push_back('{1'b0, 1'b1, 32'h0F0F_1234, t0 + 3});
    wait_resp("after_rst"); end_req();

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
